fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, default 8, program-counter width in bits.
REQ-002 Parameter: INST_W, default 32, instruction width in bits.
REQ-003 Parameter: DEPTH, default 256, instruction-memory words; SHALL satisfy DEPTH <= 2**PC_W.
REQ-004 Parameter: RESET_PC, default 0, PC value loaded at reset.
REQ-005 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port: rst  in  1  reset, synchronous, active-low.
REQ-007 Port: stall  in  1  when high, blocks any new fetch.
REQ-008 Port: redirect  in  1  branch/jump request, single-cycle pulse.
REQ-009 Port: redirect_mode  in  1  0 = absolute, 1 = PC-relative.
REQ-010 Port: redirect_target  in  PC_W  absolute address, or two's-complement offset when relative.
REQ-011 Port: inst_ready  in  1  consumer accepts the output instruction.
REQ-012 Port: prog_we, prog_addr, prog_data  in  1/PC_W/INST_W  instruction-memory write port.
REQ-013 Port: pc  out  PC_W  address of the next instruction to fetch.
REQ-014 Port: inst, inst_pc, inst_valid  out  INST_W/PC_W/1  registered fetched instruction, its address, and its valid flag.

Function
REQ-015 Define advance = !stall && (!inst_valid || inst_ready); a transfer occurs when inst_valid && inst_ready.
REQ-016 Priority SHALL be: reset > redirect > advance > transfer-only.
REQ-017 On redirect: pc <= redirect_target (mode 0) or inst_pc + redirect_target mod 2**PC_W (mode 1); inst_valid <= 0 next cycle (flush); stall is ignored.
REQ-018 On advance (no redirect): inst <= mem[pc]; inst_pc <= pc; inst_valid <= 1; pc <= pc + 1.
REQ-019 On transfer with stall high (no redirect): inst_valid <= 0; pc is unchanged.
REQ-020 Otherwise all registers SHALL hold; inst, inst_pc, and inst_valid stay stable while inst_valid && !inst_ready.
REQ-021 Fetch latency SHALL be 1 cycle, address presented on pc to inst valid; sustained throughput 1 instruction per cycle with inst_ready held high.
REQ-022 PC arithmetic SHALL wrap modulo 2**PC_W with no flag (e.g. PC_W=8: 255 -> 0).
REQ-023 Fetch from pc >= DEPTH SHALL return inst = 0 with inst_valid = 1.
REQ-024 Memory read SHALL be asynchronous within the unit and captured by the output register.
REQ-025 A write to the address being fetched in the same cycle SHALL deliver the old data; the new data SHALL be visible from the next cycle.
REQ-026 Writes with prog_addr >= DEPTH SHALL be ignored.
REQ-027 Memory writes SHALL proceed regardless of stall, redirect, or handshake state.

Reset
REQ-028 While rst = 0 at a rising edge: pc <= RESET_PC; inst_valid <= 0; inst <= 0; inst_pc <= 0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 prog_we SHALL be honoured during reset.
REQ-031 Reset asserted mid-operation SHALL discard any pending or held instruction.
REQ-032 The first fetch after reset release SHALL be from RESET_PC when advance is true.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the redirect_mode enum (REDIR_ABS, REDIR_REL) and the default values for PC_W, INST_W, and DEPTH.
REQ-034 Sub-module inst_ram SHALL contain the storage (DEPTH x INST_W array, one synchronous write port, one asynchronous read port).
REQ-035 All PC, handshake, and flush logic SHALL reside in fetch_unit.

Verification
REQ-036 Streaming: load mem[0..3] = 0xA0..0xA3; release reset with inst_ready = 1 -> inst = 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles; inst_pc = 0..3.
REQ-037 Backpressure: inst_ready = 0 for 3 cycles while inst = 0xA1 -> inst, inst_pc, and pc held; 0xA2 appears 1 cycle after inst_ready returns high.
REQ-038 Redirect: absolute target 0x40 while inst_pc = 5 -> inst_valid = 0 the next cycle, then inst_pc = 0x40; relative offset 0xFE at inst_pc = 0x10 -> next inst_pc = 0x0E.
REQ-039 Stall plus transfer: stall = 1 and inst_ready = 1 with inst_valid = 1 -> inst_valid = 0 next cycle and pc unchanged; redirect during stall still loads pc.
REQ-040 Wrap and range: PC_W = 8, DEPTH = 200, pc = 199 -> fetch mem[199], then inst = 0 for pc 200..255, then pc wraps to 0 and fetch resumes from mem[0].
REQ-041 Reset mid-stream: rst = 0 for 1 cycle while inst_valid = 1 -> inst_valid = 0 and pc = RESET_PC; memory contents intact on refetch.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default geometry for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic {
        REDIR_ABS = 1'b0,
        REDIR_REL = 1'b1
    } redir_mode_e;

    localparam int unsigned PC_W_DEF   = 8;
    localparam int unsigned INST_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 256;

endpackage

// File: rtl/fetch_unit_inst_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Out-of-range reads return zero; out-of-range writes are dropped.
module inst_ram
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = PC_W_DEF,
    parameter int unsigned DATA_W = INST_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              w_in_range;
    logic              r_in_range;

    assign w_in_range = 32'(waddr) < 32'(DEPTH);
    assign r_in_range = 32'(raddr) < 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (we && w_in_range) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    assign rdata = r_in_range ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, redirect/flush, and a registered valid/ready
// output slot fed from an asynchronous instruction RAM.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     INST_W   = INST_W_DEF,
    parameter int unsigned     DEPTH    = DEPTH_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic              redirect_mode,
    input  logic [PC_W-1:0]   redirect_target,
    input  logic              inst_ready,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [INST_W-1:0] prog_data,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid
);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] rd_data;
    logic              advance;
    logic              transfer;

    inst_ram #(
        .ADDR_W (PC_W),
        .DATA_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (rd_data)
    );

    assign advance  = !stall && (!inst_valid_q || inst_ready);
    assign transfer = inst_valid_q && inst_ready;

    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        if (redirect) begin
            // Flush only clears valid; the relative base is the PC of the slot being flushed.
            if (redir_mode_e'(redirect_mode) == REDIR_REL) begin
                pc_d = inst_pc_q + redirect_target;
            end else begin
                pc_d = redirect_target;
            end
            inst_valid_d = 1'b0;
        end else if (advance) begin
            inst_d       = rd_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 1'b1;
        end else if (transfer) begin
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetches are queued as stimulus is
// applied and popped when the output slot is sampled.
module tb_fetch_unit;

    localparam int unsigned PW = 8;
    localparam int unsigned IW = 32;
    localparam int unsigned DP = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          redirect;
    logic          redirect_mode;
    logic [PW-1:0] redirect_target;
    logic          inst_ready;
    logic          prog_we;
    logic [PW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [PW-1:0] pc;
    logic [IW-1:0] inst;
    logic [PW-1:0] inst_pc;
    logic          inst_valid;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_W     (PW),
        .INST_W   (IW),
        .DEPTH    (DP),
        .RESET_PC (8'h00)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_mode   (redirect_mode),
        .redirect_target (redirect_target),
        .inst_ready      (inst_ready),
        .prog_we         (prog_we),
        .prog_addr       (prog_addr),
        .prog_data       (prog_data),
        .pc              (pc),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid)
    );

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [PW-1:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [IW-1:0] memval(input int unsigned a);
        return 32'hA0 + a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL sb_empty: observed no queued entry expected one at time %0t", $time);
        end else begin
            e = sb.pop_front();
            chk("inst_valid", 64'(inst_valid), 64'd1);
            chk("inst", 64'(inst), 64'(e.inst));
            chk("inst_pc", 64'(inst_pc), 64'(e.pc));
        end
    endtask

    task automatic fetch_exp(input logic [PW-1:0] a, input logic [IW-1:0] d);
        sb.push_back('{inst: d, pc: a});
        cycle();
        check_out();
    endtask

    task automatic do_redirect(input logic mode, input logic [PW-1:0] tgt, input logic [PW-1:0] exp_pc);
        redirect        = 1'b1;
        redirect_mode   = mode;
        redirect_target = tgt;
        cycle();
        redirect = 1'b0;
        chk("flush_valid", 64'(inst_valid), 64'd0);
        chk("redir_pc", 64'(pc), 64'(exp_pc));
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_mode = 1'b0;
        redirect_target = '0; inst_ready = 1'b0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;

        // Load memory while held in reset; one extra write beyond DEPTH.
        for (int unsigned i = 0; i < DP; i++) begin
            prog_we = 1'b1; prog_addr = PW'(i); prog_data = memval(i);
            cycle();
        end
        prog_addr = 8'd250; prog_data = 32'hDEAD_BEEF;
        cycle();
        prog_we = 1'b0;
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);

        // Streaming from reset
        rst = 1'b1; inst_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) fetch_exp(PW'(i), memval(i));
        chk("stream_pc", 64'(pc), 64'd4);

        // Backpressure at inst = A1
        do_redirect(1'b0, 8'd1, 8'd1);
        fetch_exp(8'd1, memval(1));
        inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_valid", 64'(inst_valid), 64'd1);
            chk("bp_inst", 64'(inst), 64'(memval(1)));
            chk("bp_inst_pc", 64'(inst_pc), 64'd1);
            chk("bp_pc", 64'(pc), 64'd2);
        end
        inst_ready = 1'b1;
        fetch_exp(8'd2, memval(2));
        fetch_exp(8'd3, memval(3));
        fetch_exp(8'd4, memval(4));
        fetch_exp(8'd5, memval(5));

        // Absolute redirect at inst_pc 5, then relative -2 at inst_pc 0x10
        do_redirect(1'b0, 8'h40, 8'h40);
        fetch_exp(8'h40, memval(8'h40));
        do_redirect(1'b0, 8'h10, 8'h10);
        fetch_exp(8'h10, memval(8'h10));
        do_redirect(1'b1, 8'hFE, 8'h0E);
        fetch_exp(8'h0E, memval(8'h0E));

        // Stall with transfer, then redirect while stalled
        stall = 1'b1;
        cycle();
        chk("stall_xfer_valid", 64'(inst_valid), 64'd0);
        chk("stall_xfer_pc", 64'(pc), 64'h0F);
        cycle();
        chk("stall_hold_valid", 64'(inst_valid), 64'd0);
        chk("stall_hold_pc", 64'(pc), 64'h0F);
        do_redirect(1'b0, 8'h20, 8'h20);
        cycle();
        chk("stall_redir_hold_pc", 64'(pc), 64'h20);
        chk("stall_redir_hold_valid", 64'(inst_valid), 64'd0);
        stall = 1'b0;
        fetch_exp(8'h20, memval(8'h20));

        // Last valid word, out-of-range zeros (incl. dropped write at 250), wrap
        do_redirect(1'b0, 8'd199, 8'd199);
        fetch_exp(8'd199, memval(199));
        for (int unsigned a = 200; a < 256; a++) fetch_exp(PW'(a), '0);
        chk("wrap_pc", 64'(pc), 64'd0);
        fetch_exp(8'd0, memval(0));
        fetch_exp(8'd1, memval(1));

        // Reset mid-stream with a valid instruction held
        rst = 1'b0;
        cycle();
        chk("mid_rst_valid", 64'(inst_valid), 64'd0);
        chk("mid_rst_pc", 64'(pc), 64'd0);
        chk("mid_rst_inst", 64'(inst), 64'd0);
        chk("mid_rst_inst_pc", 64'(inst_pc), 64'd0);
        rst = 1'b1;
        fetch_exp(8'd0, memval(0));
        fetch_exp(8'd1, memval(1));

        // Same-cycle write to the fetched address returns old data
        prog_we = 1'b1; prog_addr = 8'd2; prog_data = 32'h0000_0055;
        fetch_exp(8'd2, memval(2));
        prog_we = 1'b0;
        do_redirect(1'b0, 8'd2, 8'd2);
        fetch_exp(8'd2, 32'h0000_0055);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
